// File: rtl/strip_frame_assembler.sv
// Strip-mode TDS frame assembler: gathers header-tagged words into WORDS-payload
// frames, registers the link-status word and keeps saturating error statistics.
module strip_frame_assembler #(
    parameter int unsigned       HDR_W  = 4,
    parameter int unsigned       PAY_W  = 26,
    parameter logic [HDR_W-1:0]  HEADER = 4'b1010,
    parameter int unsigned       WORDS  = 4,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic                     clk160,
    input  logic                     reset,
    input  logic [HDR_W+PAY_W-1:0]   strip_data_in,
    input  logic [18:0]              link_message,
    input  logic                     clear_counters,
    output logic                     linked,
    output logic [3:0]               state,
    output logic [8:0]               syn_cnt,
    output logic [4:0]               err_cnt,
    output logic [WORDS*PAY_W-1:0]   frame_data,
    output logic                     frame_valid,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic [CNT_W-1:0]         short_cnt,
    output logic [CNT_W-1:0]         long_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned IDX_W = $clog2(WORDS + 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(WORDS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]             fsm_q, fsm_d;
    logic [IDX_W-1:0]       idx_q;
    logic [WORDS*PAY_W-1:0] asm_q;
    logic                   match, lk;
    logic [PAY_W-1:0]       payload;
    logic                   good_run, short_run, long_run, drop_evt;

    assign match    = (strip_data_in[HDR_W+PAY_W-1:PAY_W] == HEADER);
    assign payload  = strip_data_in[PAY_W-1:0];
    assign lk       = link_message[14];
    assign drop_evt = linked & ~lk;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        fsm_d     = fsm_q;
        good_run  = 1'b0;
        short_run = 1'b0;
        long_run  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (lk && match) fsm_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (!lk) begin
                    fsm_d = S_IDLE;
                end else if (match) begin
                    if (idx_q == IDX_FULL) begin
                        long_run = 1'b1;
                        fsm_d    = S_DISCARD;
                    end
                end else begin
                    fsm_d = S_IDLE;
                    if (idx_q == IDX_FULL) good_run = 1'b1;
                    else                   short_run = 1'b1;
                end
            end
            S_DISCARD: begin
                if (!match || !lk) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // Stale slots left by an aborted run are always overwritten before the next emit.
    always_ff @(posedge clk160) begin
        if (reset) begin
            fsm_q       <= S_IDLE;
            idx_q       <= '0;
            asm_q       <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            frame_valid <= good_run;
            if (good_run) frame_data <= asm_q;
            if (fsm_q == S_IDLE && lk && match) begin
                asm_q[WORDS*PAY_W-1 -: PAY_W] <= payload;
                idx_q <= IDX_W'(1);
            end else if (fsm_q == S_COLLECT && lk && match && idx_q != IDX_FULL) begin
                for (int unsigned s = 1; s < WORDS; s++) begin
                    if (idx_q == IDX_W'(s)) asm_q[(WORDS-s)*PAY_W-1 -: PAY_W] <= payload;
                end
                idx_q <= idx_q + IDX_W'(1);
            end else if (fsm_d != S_COLLECT) begin
                idx_q <= '0;
            end
        end
    end

    always_ff @(posedge clk160) begin
        if (reset) begin
            linked  <= 1'b0;
            state   <= '0;
            syn_cnt <= '0;
            err_cnt <= '0;
        end else begin
            linked  <= link_message[14];
            state   <= link_message[18:15];
            syn_cnt <= link_message[13:5];
            err_cnt <= link_message[4:0];
        end
    end

    always_ff @(posedge clk160) begin
        if (reset || clear_counters) begin
            frame_cnt <= '0;
            short_cnt <= '0;
            long_cnt  <= '0;
            drop_cnt  <= '0;
        end else begin
            if (good_run)  frame_cnt <= sat_inc(frame_cnt);
            if (short_run) short_cnt <= sat_inc(short_cnt);
            if (long_run)  long_cnt  <= sat_inc(long_cnt);
            if (drop_evt)  drop_cnt  <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_strip_frame_assembler.sv
// Directed bench: instance A uses default parameters, instance B uses WORDS=8
// with 4-bit counters for the wide-frame and saturation scenarios.
module tb_strip_frame_assembler;

    logic         clk160 = 1'b0;
    logic         reset;
    logic [29:0]  data_a, data_b;
    logic [18:0]  lm;
    logic         clear;

    logic         linked_a, fv_a, linked_b, fv_b;
    logic [3:0]   state_a, state_b;
    logic [8:0]   syn_a, syn_b;
    logic [4:0]   err_a, err_b;
    logic [103:0] fd_a;
    logic [207:0] fd_b;
    logic [15:0]  fcnt_a, scnt_a, lcnt_a, dcnt_a;
    logic [3:0]   fcnt_b, scnt_b, lcnt_b, dcnt_b;

    int checks = 0;
    int errors = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    always #5 clk160 = ~clk160;

    strip_frame_assembler #(.HDR_W(4), .PAY_W(26), .HEADER(4'b1010), .WORDS(4), .CNT_W(16)) u_dut_a (
        .clk160(clk160), .reset(reset), .strip_data_in(data_a), .link_message(lm),
        .clear_counters(clear), .linked(linked_a), .state(state_a), .syn_cnt(syn_a),
        .err_cnt(err_a), .frame_data(fd_a), .frame_valid(fv_a), .frame_cnt(fcnt_a),
        .short_cnt(scnt_a), .long_cnt(lcnt_a), .drop_cnt(dcnt_a)
    );

    strip_frame_assembler #(.HDR_W(4), .PAY_W(26), .HEADER(4'b1010), .WORDS(8), .CNT_W(4)) u_dut_b (
        .clk160(clk160), .reset(reset), .strip_data_in(data_b), .link_message(lm),
        .clear_counters(clear), .linked(linked_b), .state(state_b), .syn_cnt(syn_b),
        .err_cnt(err_b), .frame_data(fd_b), .frame_valid(fv_b), .frame_cnt(fcnt_b),
        .short_cnt(scnt_b), .long_cnt(lcnt_b), .drop_cnt(dcnt_b)
    );

    always @(negedge clk160) begin
        if (fv_a === 1'b1) pulses_a++;
        if (fv_b === 1'b1) pulses_b++;
    end

    task automatic step();
        @(negedge clk160);
        #1;
    endtask

    task automatic hdr_a(input logic [25:0] p);
        data_a = {4'b1010, p};
        step();
    endtask

    task automatic idle_a();
        data_a = '0;
        step();
    endtask

    task automatic hdr_b(input logic [25:0] p);
        data_b = {4'b1010, p};
        step();
    endtask

    task automatic idle_b();
        data_b = '0;
        step();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        clear  = 1'b1;
        lm     = {4'hF, 1'b1, 9'h1FF, 5'h1F};
        data_a = {4'b1010, 26'h3};
        data_b = '0;
        step();
        step();
        checks++; if ({linked_a, state_a, syn_a, err_a} !== 19'h0) begin errors++; $display("FAIL reset_link got %h expected 0", {linked_a, state_a, syn_a, err_a}); end
        checks++; if (fd_a !== '0 || fv_a !== 1'b0) begin errors++; $display("FAIL reset_frame got fd=%h fv=%b expected 0", fd_a, fv_a); end
        checks++; if ({fcnt_a, scnt_a, lcnt_a, dcnt_a} !== 64'h0) begin errors++; $display("FAIL reset_cnt_a got %h expected 0", {fcnt_a, scnt_a, lcnt_a, dcnt_a}); end
        checks++; if ({fv_b, fcnt_b, scnt_b, lcnt_b, dcnt_b} !== 17'h0 || fd_b !== '0) begin errors++; $display("FAIL reset_b got %h expected 0", {fv_b, fcnt_b, scnt_b, lcnt_b, dcnt_b}); end
        reset  = 1'b0;
        clear  = 1'b0;
        data_a = '0;
        lm     = {4'h3, 1'b1, 9'h0AB, 5'h15};
    endtask

    task automatic test_link_fields();
        step();
        checks++; if ({state_a, linked_a, syn_a, err_a} !== {4'h3, 1'b1, 9'h0AB, 5'h15}) begin errors++; $display("FAIL link_fields1 got %h expected %h", {state_a, linked_a, syn_a, err_a}, {4'h3, 1'b1, 9'h0AB, 5'h15}); end
        lm = {4'hC, 1'b1, 9'h155, 5'h0A};
        checks++; if (state_a !== 4'h3) begin errors++; $display("FAIL link_latency got %h expected 3", state_a); end
        step();
        checks++; if ({state_a, linked_a, syn_a, err_a} !== {4'hC, 1'b1, 9'h155, 5'h0A}) begin errors++; $display("FAIL link_fields2 got %h expected %h", {state_a, linked_a, syn_a, err_a}, {4'hC, 1'b1, 9'h155, 5'h0A}); end
    endtask

    task automatic test_good_frame();
        int p0;
        p0 = pulses_a;
        idle_a();
        hdr_a(26'h1111111);
        hdr_a(26'h2222222);
        hdr_a(26'h3333333);
        hdr_a(26'h0444444);
        checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL good_early got fv=%b expected 0", fv_a); end
        idle_a();
        checks++; if (fv_a !== 1'b1) begin errors++; $display("FAIL good_valid got fv=%b expected 1", fv_a); end
        checks++; if (fd_a !== {26'h1111111, 26'h2222222, 26'h3333333, 26'h0444444}) begin errors++; $display("FAIL good_data got %h", fd_a); end
        checks++; if (fcnt_a !== 16'd1) begin errors++; $display("FAIL good_cnt got %0d expected 1", fcnt_a); end
        idle_a();
        checks++; if (fv_a !== 1'b0 || pulses_a !== p0 + 1) begin errors++; $display("FAIL good_pulse got fv=%b pulses=%0d expected 0 and %0d", fv_a, pulses_a - p0, 1); end
    endtask

    task automatic test_short_long();
        int p0;
        p0 = pulses_a;
        for (int i = 0; i < 3; i++) hdr_a(26'h0000100 + 26'(i));
        idle_a();
        checks++; if (scnt_a !== 16'd1) begin errors++; $display("FAIL short_cnt got %0d expected 1", scnt_a); end
        for (int i = 0; i < 6; i++) hdr_a(26'h0000200 + 26'(i));
        idle_a();
        idle_a();
        checks++; if (lcnt_a !== 16'd1 || scnt_a !== 16'd1) begin errors++; $display("FAIL long_cnt got long=%0d short=%0d expected 1 1", lcnt_a, scnt_a); end
        checks++; if (pulses_a !== p0 || fcnt_a !== 16'd1) begin errors++; $display("FAIL short_long_novalid got pulses=%0d fcnt=%0d expected 0 1", pulses_a - p0, fcnt_a); end
        checks++; if (fd_a !== {26'h1111111, 26'h2222222, 26'h3333333, 26'h0444444}) begin errors++; $display("FAIL short_long_data got %h", fd_a); end
    endtask

    task automatic test_link_drop();
        int p0;
        p0 = pulses_a;
        hdr_a(26'h0AAAAAA);
        hdr_a(26'h0BBBBBB);
        lm[14] = 1'b0;
        hdr_a(26'h0CCCCCC);
        checks++; if (dcnt_a !== 16'd1 || linked_a !== 1'b0) begin errors++; $display("FAIL drop_cnt got %0d linked=%b expected 1 0", dcnt_a, linked_a); end
        lm[14] = 1'b1;
        idle_a();
        hdr_a(26'h0000C01);
        hdr_a(26'h0000C02);
        hdr_a(26'h0000C03);
        hdr_a(26'h0000C04);
        idle_a();
        checks++; if (fv_a !== 1'b1 || fd_a !== {26'h0000C01, 26'h0000C02, 26'h0000C03, 26'h0000C04}) begin errors++; $display("FAIL drop_frame got fv=%b fd=%h", fv_a, fd_a); end
        checks++; if ({fcnt_a, scnt_a, lcnt_a, dcnt_a} !== {16'd2, 16'd1, 16'd1, 16'd1}) begin errors++; $display("FAIL drop_counts got %h expected 0002000100010001", {fcnt_a, scnt_a, lcnt_a, dcnt_a}); end
        checks++; if (pulses_a !== p0 + 1) begin errors++; $display("FAIL drop_pulses got %0d expected 1", pulses_a - p0); end
    endtask

    task automatic test_back_to_back();
        logic [103:0] exp;
        logic [25:0]  p;
        clear = 1'b1;
        idle_a();
        clear = 1'b0;
        checks++; if ({fcnt_a, scnt_a, lcnt_a, dcnt_a} !== 64'h0) begin errors++; $display("FAIL clear_a got %h expected 0", {fcnt_a, scnt_a, lcnt_a, dcnt_a}); end
        checks++; if (fd_a !== {26'h0000C01, 26'h0000C02, 26'h0000C03, 26'h0000C04}) begin errors++; $display("FAIL clear_keeps_data got %h", fd_a); end
        for (int f = 0; f < 100; f++) begin
            exp = '0;
            for (int j = 0; j < 4; j++) begin
                p   = {8'(f), 2'(j), 16'hBEEF};
                exp = {exp[77:0], p};
                hdr_a(p);
                checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL b2b_gap frame %0d word %0d got fv=%b expected 0", f, j, fv_a); end
            end
            idle_a();
            checks++; if (fv_a !== 1'b1 || fd_a !== exp) begin errors++; $display("FAIL b2b_frame %0d got fv=%b fd=%h expected %h", f, fv_a, fd_a, exp); end
        end
        checks++; if (fcnt_a !== 16'd100) begin errors++; $display("FAIL b2b_cnt got %0d expected 100", fcnt_a); end
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        hdr_a(26'h0DEAD01);
        hdr_a(26'h0DEAD02);
        reset = 1'b1;
        data_a = {4'b1010, 26'h0DEAD03};
        step();
        checks++; if (fd_a !== '0 || fv_a !== 1'b0 || {linked_a, state_a, syn_a, err_a} !== 19'h0) begin errors++; $display("FAIL midreset_out got fd=%h link=%h expected 0", fd_a, {linked_a, state_a, syn_a, err_a}); end
        checks++; if ({fcnt_a, scnt_a, lcnt_a, dcnt_a} !== 64'h0) begin errors++; $display("FAIL midreset_cnt got %h expected 0", {fcnt_a, scnt_a, lcnt_a, dcnt_a}); end
        reset = 1'b0;
        idle_a();
        p0 = pulses_a;
        hdr_a(26'h0000E01);
        hdr_a(26'h0000E02);
        hdr_a(26'h0000E03);
        hdr_a(26'h0000E04);
        idle_a();
        checks++; if (fv_a !== 1'b1 || fd_a !== {26'h0000E01, 26'h0000E02, 26'h0000E03, 26'h0000E04}) begin errors++; $display("FAIL midreset_frame got fv=%b fd=%h", fv_a, fd_a); end
        checks++; if (fcnt_a !== 16'd1 || scnt_a !== 16'd0 || pulses_a !== p0 + 1) begin errors++; $display("FAIL midreset_counts got fcnt=%0d short=%0d pulses=%0d expected 1 0 1", fcnt_a, scnt_a, pulses_a - p0); end
    endtask

    task automatic test_wide_frame(output logic [207:0] exp);
        logic [25:0] p;
        exp = '0;
        for (int k = 0; k < 8; k++) begin
            p   = {2'b01, 8'(k + 1), 16'h5A00 | 16'(k)};
            exp = {exp[181:0], p};
            hdr_b(p);
        end
        checks++; if (fv_b !== 1'b0) begin errors++; $display("FAIL wide_early got fv=%b expected 0", fv_b); end
        idle_b();
        checks++; if (fv_b !== 1'b1 || fd_b !== exp) begin errors++; $display("FAIL wide_data got fv=%b fd=%h expected %h", fv_b, fd_b, exp); end
        checks++; if (fcnt_b !== 4'd1) begin errors++; $display("FAIL wide_cnt got %0d expected 1", fcnt_b); end
    endtask

    task automatic test_saturation(input logic [207:0] exp);
        for (int r = 0; r < 20; r++) begin
            hdr_b(26'h1);
            hdr_b(26'h2);
            idle_b();
            if (r == 13) begin
                checks++; if (scnt_b !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d expected 14", scnt_b); end
            end
        end
        checks++; if (scnt_b !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d expected 15", scnt_b); end
        hdr_b(26'h1);
        hdr_b(26'h2);
        data_b = '0;
        clear  = 1'b1;
        step();
        clear  = 1'b0;
        checks++; if (scnt_b !== 4'd0 || fcnt_b !== 4'd0) begin errors++; $display("FAIL clear_wins got short=%0d frame=%0d expected 0 0", scnt_b, fcnt_b); end
        checks++; if (fd_b !== exp) begin errors++; $display("FAIL clear_data_b got %h expected %h", fd_b, exp); end
        hdr_b(26'h3);
        idle_b();
        checks++; if (scnt_b !== 4'd1) begin errors++; $display("FAIL after_clear got %0d expected 1", scnt_b); end
    endtask

    initial begin
        logic [207:0] wide_exp;
        test_reset();
        test_link_fields();
        test_good_frame();
        test_short_long();
        test_link_drop();
        test_back_to_back();
        test_reset_mid_frame();
        test_wide_frame(wide_exp);
        test_saturation(wide_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
